// File: rtl/shamt_sel_fifo.sv
// shamt_sel_fifo: shift-amount source mux feeding a small valid/ready FIFO.
// Holds a selected shift amount (plus an out-of-range flag) across the
// stall cycles between the control unit and the shifter.
module shamt_sel_fifo #(
  parameter int WIDTH     = 6,
  parameter int N_SRC     = 4,
  parameter int SEL_W     = 3,
  parameter int CONST_IDX = 1,
  parameter int CONST_VAL = 16,
  parameter int DEPTH     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         sel,
  input  logic [N_SRC*WIDTH-1:0]   data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         data_out,
  output logic                     sel_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] val;
  } entry_t;

  logic [N_SRC-1:0][WIDTH-1:0] slots;
  entry_t                      sel_ent;
  entry_t                      mem [DEPTH];
  entry_t                      head;
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic                        push;
  logic                        pop;

  // Unpack the flat operand bus into per-slot fields.
  for (genvar k = 0; k < N_SRC; k++) begin : g_slot
    assign slots[k] = data_in[k*WIDTH +: WIDTH];
  end

  // Source selection: constant slot, in-range slot, or slot 0 flagged as error.
  always_comb begin
    sel_ent.err = 1'b1;
    sel_ent.val = slots[0];
    for (int k = 0; k < N_SRC; k++) begin
      if ({1'b0, sel} == (SEL_W+1)'(k)) begin
        sel_ent.err = 1'b0;
        sel_ent.val = (k == CONST_IDX) ? WIDTH'(CONST_VAL) : slots[k];
      end
    end
  end

  // Handshakes; no bypass when full, so pop never frees a slot the same cycle.
  assign in_ready  = reset & (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head entry, forced to zero when the queue is empty.
  assign head     = mem[rd_ptr];
  assign data_out = out_valid ? head.val : '0;
  assign sel_err  = out_valid & head.err;

  // Pointer/occupancy update; reset beats flush beats push/pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= sel_ent;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_shamt_sel_fifo.sv
// Directed bench for shamt_sel_fifo: selection, ordering, full/flush/reset.
module tb_shamt_sel_fifo;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, sel_err;
  logic [2:0]  sel;
  logic [23:0] data_in;
  logic [5:0]  data_out;
  logic [1:0]  count;
  int          nvec = 0;
  int          nerr = 0;

  shamt_sel_fifo dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .sel(sel), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .sel_err(sel_err), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pack(input logic [5:0] s0, s1, s2, s3);
    return {s3, s2, s1, s0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sel = '0; data_in = '0;

    // reset
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_err", 32'(sel_err), 0);
    reset = 1'b1; #1;
    chk("rel_ready", 32'(in_ready), 1);

    // constant slot
    in_valid = 1'b1; sel = 3'd1; data_in = pack(6'd0, 6'd5, 6'd0, 6'd0);
    tick(); in_valid = 1'b0;
    chk("const_valid", 32'(out_valid), 1);
    chk("const_data", 32'(data_out), 16);
    chk("const_err", 32'(sel_err), 0);
    chk("const_count", 32'(count), 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("pop1_count", 32'(count), 0);
    chk("empty_data", 32'(data_out), 0);

    // two pushes, hold, drain in order
    in_valid = 1'b1; sel = 3'd2; data_in = pack(6'd0, 6'd0, 6'd9, 6'd33);
    tick(); sel = 3'd3;
    tick(); in_valid = 1'b0;
    chk("full_count", 32'(count), 2);
    chk("full_ready", 32'(in_ready), 0);
    chk("head9", 32'(data_out), 9);
    tick();
    chk("hold9", 32'(data_out), 9);
    chk("hold_count", 32'(count), 2);
    out_ready = 1'b1; tick();
    chk("head33", 32'(data_out), 33);
    chk("drain_count", 32'(count), 1);
    tick(); out_ready = 1'b0;
    chk("drained", 32'(out_valid), 0);

    // out-of-range select
    in_valid = 1'b1; sel = 3'd5; data_in = pack(6'd7, 6'd1, 6'd2, 6'd3);
    tick(); in_valid = 1'b0;
    chk("oor_data", 32'(data_out), 7);
    chk("oor_err", 32'(sel_err), 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("oor_pop", 32'(count), 0);

    // full push+pop, then half-full push+pop across wrap
    in_valid = 1'b1; sel = 3'd0; data_in = pack(6'd1, 6'd0, 6'd0, 6'd0);
    tick(); data_in = pack(6'd2, 6'd0, 6'd0, 6'd0);
    tick();
    chk("fill_count", 32'(count), 2);
    data_in = pack(6'd3, 6'd0, 6'd0, 6'd0); out_ready = 1'b1;
    tick();
    chk("fullpp_count", 32'(count), 1);
    chk("fullpp_head", 32'(data_out), 2);
    tick();
    chk("halfpp_count", 32'(count), 1);
    chk("halfpp_head", 32'(data_out), 3);
    data_in = pack(6'd4, 6'd0, 6'd0, 6'd0);
    tick(); in_valid = 1'b0;
    chk("wrap_count", 32'(count), 1);
    chk("wrap_head", 32'(data_out), 4);
    tick(); out_ready = 1'b0;
    chk("wrap_empty", 32'(count), 0);

    // flush with a concurrent push and pop
    in_valid = 1'b1; data_in = pack(6'd10, 6'd0, 6'd0, 6'd0);
    tick(); data_in = pack(6'd11, 6'd0, 6'd0, 6'd0);
    tick();
    chk("preflush_count", 32'(count), 2);
    flush = 1'b1; out_ready = 1'b1; data_in = pack(6'd12, 6'd0, 6'd0, 6'd0);
    tick(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(out_valid), 0);
    tick();
    chk("flush_nopush", 32'(count), 0);
    in_valid = 1'b1; data_in = pack(6'd13, 6'd0, 6'd0, 6'd0);
    tick(); in_valid = 1'b0;
    chk("postflush_head", 32'(data_out), 13);

    // reset mid-stream with a push pending
    in_valid = 1'b1; data_in = pack(6'd14, 6'd0, 6'd0, 6'd0);
    tick();
    chk("prerst_count", 32'(count), 2);
    reset = 1'b0;
    tick();
    chk("midrst_count", 32'(count), 0);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_ready", 32'(in_ready), 0);
    reset = 1'b1; in_valid = 1'b0;
    tick();
    chk("postrst_count", 32'(count), 0);
    chk("postrst_data", 32'(data_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
